alu_issuer: RTL and testbench

Instruction-side counterpart of the processor ALU: accepts register-addressed ALU instructions over a valid/ready handshake and reads operands from a local register file. It drives the ALU's `ctrl`/`in0`/`in1` inputs, waits for the ALU's one-cycle input-register latency, captures the result and writes it back. It sits between the instruction decoder and the ALU and owns the general-purpose data registers.

---
 rtl/alu_issuer.sv | 131 +++++++++++++
 tb/tb_alu_issuer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issuer.sv
// Serialises register-addressed ALU instructions: operand fetch, ALU drive, result capture, write-back.
// Optional build macro ALU_ISSUER_ZERO_REG_EN makes reg[0] a hard-wired zero.
module alu_issuer #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      instr_valid,
    output logic                      instr_ready,
    input  logic [2:0]                instr_op,
    input  logic [REG_ADDR_WIDTH-1:0] instr_rd,
    input  logic [REG_ADDR_WIDTH-1:0] instr_rs0,
    input  logic [REG_ADDR_WIDTH-1:0] instr_rs1,
    input  logic [DATA_WIDTH-1:0]     instr_imm,
    input  logic                      instr_use_imm,
    output logic [2:0]                alu_ctrl,
    output logic [DATA_WIDTH-1:0]     alu_in0,
    output logic [DATA_WIDTH-1:0]     alu_in1,
    input  logic [DATA_WIDTH-1:0]     alu_out,
    output logic                      res_valid,
    output logic [DATA_WIDTH-1:0]     res_data,
    output logic [REG_ADDR_WIDTH-1:0] res_rd
);

    localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_EXEC,
        S_WB
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [DATA_WIDTH-1:0]       r_regs [NUM_REGS];
    logic [2:0]                  r_ctrl;
    logic [DATA_WIDTH-1:0]       r_in0;
    logic [DATA_WIDTH-1:0]       r_in1;
    logic [REG_ADDR_WIDTH-1:0]   r_rd;
    logic [DATA_WIDTH-1:0]       r_result;
    logic [REG_ADDR_WIDTH-1:0]   r_res_rd;
    logic                        w_accept;
    logic                        w_wb_en;
    logic [DATA_WIDTH-1:0]       w_rs0_val;
    logic [DATA_WIDTH-1:0]       w_rs1_val;
    logic [DATA_WIDTH-1:0]       w_in1;

`ifdef ALU_ISSUER_ZERO_REG_EN
    assign w_rs0_val = (instr_rs0 == '0) ? '0 : r_regs[instr_rs0];
    assign w_rs1_val = (instr_rs1 == '0) ? '0 : r_regs[instr_rs1];
    assign w_wb_en   = (r_state == S_WB) && (r_res_rd != '0);
`else
    assign w_rs0_val = r_regs[instr_rs0];
    assign w_rs1_val = r_regs[instr_rs1];
    assign w_wb_en   = (r_state == S_WB);
`endif

    assign w_in1    = instr_use_imm ? instr_imm : w_rs1_val;
    assign w_accept = instr_valid & instr_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        instr_ready  = 1'b0;
        res_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: w_state_next = S_EXEC;
            S_EXEC:  w_state_next = S_WB;
            S_WB: begin
                res_valid    = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ALU inputs are only reloaded on accept so they stay stable through WB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl   <= '0;
            r_in0    <= '0;
            r_in1    <= '0;
            r_rd     <= '0;
            r_result <= '0;
            r_res_rd <= '0;
        end else begin
            if (w_accept) begin
                r_ctrl <= instr_op;
                r_in0  <= w_rs0_val;
                r_in1  <= w_in1;
                r_rd   <= instr_rd;
            end
            if (r_state == S_EXEC) begin
                r_result <= alu_out;
                r_res_rd <= r_rd;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_en) begin
            r_regs[r_res_rd] <= r_result;
        end
    end

    assign alu_ctrl = r_ctrl;
    assign alu_in0  = r_in0;
    assign alu_in1  = r_in1;
    assign res_data = r_result;
    assign res_rd   = r_res_rd;

endmodule

// File: tb/tb_alu_issuer.sv
// Scoreboard bench for alu_issuer with a behavioural ALU stub and a register-file reference model.
module tb_alu_issuer;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NR = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          instr_valid = 1'b0;
    logic          instr_ready;
    logic [2:0]    instr_op = '0;
    logic [AW-1:0] instr_rd = '0;
    logic [AW-1:0] instr_rs0 = '0;
    logic [AW-1:0] instr_rs1 = '0;
    logic [DW-1:0] instr_imm = '0;
    logic          instr_use_imm = 1'b0;
    logic [2:0]    alu_ctrl;
    logic [DW-1:0] alu_in0;
    logic [DW-1:0] alu_in1;
    logic [DW-1:0] alu_out = '0;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic [AW-1:0] res_rd;

    alu_issuer #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd),
        .instr_rs0(instr_rs0), .instr_rs1(instr_rs1),
        .instr_imm(instr_imm), .instr_use_imm(instr_use_imm),
        .alu_ctrl(alu_ctrl), .alu_in0(alu_in0), .alu_in1(alu_in1),
        .alu_out(alu_out),
        .res_valid(res_valid), .res_data(res_data), .res_rd(res_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
        logic [2:0]    op;
        logic [DW-1:0] in0;
        logic [DW-1:0] in1;
        int            acc;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    logic [DW-1:0] mregs [NR];
    logic [DW+AW-1:0] last_res = '0;
    int            passed = 0;
    int            total = 0;
    int            cyc = 0;
    int            last_acc = -100;
    bit            prev_hold = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] alu_f(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            3'd0: return a;
            3'd1: return a + b;
            3'd2: return a - b;
            3'd3: return (a == b) ? 1 : 0;
            3'd4: return ($signed(a) <= $signed(b)) ? 1 : 0;
            3'd5: return ($signed(a) >= $signed(b)) ? 1 : 0;
            default: return '0;
        endcase
    endfunction

    // ALU stub: inputs registered, result one cycle later
    always @(posedge clk) alu_out <= alu_f(alu_ctrl, alu_in0, alu_in1);

    function automatic logic [DW-1:0] mread(input logic [AW-1:0] a);
`ifdef ALU_ISSUER_ZERO_REG_EN
        if (a == 0) return '0;
`endif
        return mregs[a];
    endfunction

    task automatic mwrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
`ifdef ALU_ISSUER_ZERO_REG_EN
        if (a == 0) return;
`endif
        mregs[a] = d;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (res_valid !== 1'b0) begin
            if (sb.size() == 0) begin
                chk("unexpected res_valid", {63'd0, res_valid}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("res_data", res_data, mon_e.data);
                chk("res_rd", res_rd, mon_e.rd);
                chk("alu_ctrl stable", alu_ctrl, mon_e.op);
                chk("alu_in0 stable", alu_in0, mon_e.in0);
                chk("alu_in1 stable", alu_in1, mon_e.in1);
                chk("wb latency", cyc - mon_e.acc, 3);
                last_res = {res_rd, res_data};
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs0,
                         input logic [AW-1:0] rs1, input logic [DW-1:0] imm, input logic ui, input bit hold);
        int   n;
        exp_t e;
        @(negedge clk);
        instr_op = op; instr_rd = rd; instr_rs0 = rs0; instr_rs1 = rs1;
        instr_imm = imm; instr_use_imm = ui; instr_valid = 1'b1;
        n = 0;
        while (instr_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (instr_ready !== 1'b1) begin
            chk("accept timeout", 64'd0, 64'd1);
            instr_valid = 1'b0;
            prev_hold = 1'b0;
            return;
        end
        chk("result hold in IDLE", {res_rd, res_data}, last_res);
        if (prev_hold) chk("back-to-back spacing", cyc - last_acc, 4);
        e.op  = op;
        e.rd  = rd;
        e.in0 = mread(rs0);
        e.in1 = ui ? imm : mread(rs1);
        e.data = alu_f(op, e.in0, e.in1);
        e.acc = cyc;
        mwrite(rd, e.data);
        sb.push_back(e);
        last_acc  = cyc;
        prev_hold = hold;
        @(negedge clk);
        chk("ready low in ISSUE", {63'd0, instr_ready}, 64'd0);
        chk("alu_in1 at ISSUE", alu_in1, e.in1);
        if (!hold) instr_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        instr_valid = 1'b0;
        sb.delete();
        for (int i = 0; i < NR; i++) mregs[i] = '0;
        last_res = '0;
        prev_hold = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset instr_ready", {63'd0, instr_ready}, 64'd1);
        chk("reset res_valid", {63'd0, res_valid}, 64'd0);
        chk("reset alu_ctrl", alu_ctrl, 0);
        chk("reset alu_in0", alu_in0, 0);
        chk("reset alu_in1", alu_in1, 0);
        chk("reset res_data", res_data, 0);
        chk("reset res_rd", res_rd, 0);
    endtask

    initial begin
        int            n;
        logic [2:0]    op;
        logic [AW-1:0] rd, rs0, rs1;
        logic [DW-1:0] imm;
        logic          ui;
        bit            hold;

        @(negedge clk);
        do_reset();

        issue(3'd0, 4'd1, 4'd0, 4'd0, 32'd5, 1'b1, 1'b0);
        issue(3'd1, 4'd1, 4'd0, 4'd0, 32'd7, 1'b1, 1'b0);
        issue(3'd2, 4'd2, 4'd1, 4'd0, 32'd9, 1'b1, 1'b0);
        issue(3'd4, 4'd3, 4'd2, 4'd0, 32'd0, 1'b1, 1'b0);
        issue(3'd5, 4'd3, 4'd2, 4'd0, 32'd0, 1'b1, 1'b0);
        issue(3'd3, 4'd4, 4'd1, 4'd0, 32'd7, 1'b1, 1'b0);
        issue(3'd6, 4'd4, 4'd1, 4'd2, 32'd0, 1'b0, 1'b0);
        issue(3'd7, 4'd5, 4'd2, 4'd1, 32'd1, 1'b1, 1'b0);

        issue(3'd1, 4'd5, 4'd1, 4'd0, 32'd10, 1'b1, 1'b1);
        issue(3'd0, 4'd6, 4'd5, 4'd0, 32'd0, 1'b1, 1'b1);
        issue(3'd1, 4'd7, 4'd6, 4'd5, 32'd0, 1'b0, 1'b1);
        issue(3'd1, 4'd7, 4'd7, 4'd7, 32'd0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);

        // abort an instruction in EXEC
        issue(3'd1, 4'd4, 4'd0, 4'd0, 32'hAA, 1'b1, 1'b0);
        @(negedge clk);
        do_reset();
        repeat (6) @(negedge clk);
        issue(3'd0, 4'd5, 4'd4, 4'd0, 32'd0, 1'b1, 1'b0);

        issue(3'd1, 4'd0, 4'd0, 4'd0, 32'd3, 1'b1, 1'b0);
        issue(3'd0, 4'd1, 4'd0, 4'd0, 32'd0, 1'b1, 1'b0);

        for (int k = 0; k < 200; k++) begin
            op  = 3'($urandom_range(0, 7));
            rd  = AW'($urandom_range(0, NR - 1));
            rs0 = AW'($urandom_range(0, NR - 1));
            rs1 = AW'($urandom_range(0, NR - 1));
            case ($urandom_range(0, 5))
                0: imm = 32'h0;
                1: imm = 32'hFFFF_FFFF;
                2: imm = 32'h8000_0000;
                3: imm = 32'h7FFF_FFFF;
                default: imm = $urandom;
            endcase
            ui   = 1'($urandom_range(0, 1));
            hold = ($urandom_range(0, 3) == 0);
            issue(op, rd, rs0, rs1, imm, ui, hold);
            if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        instr_valid = 1'b0;

        n = 0;
        while (sb.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
